swervolf_sseg_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment display controller for the SweRVolf board top levels. It captures a DIGITS×4-bit value on a load strobe and scans it across a common-anode display, one digit per slot. Each slot has a programmable anode-off gap to suppress ghosting, with per-digit enable and decimal point. It runs on the core clock and replaces the ad-hoc scanner and divided-clock logic in board tops.

---
 rtl/swervolf_sseg_pkg.sv | 30 +++
 rtl/swervolf_sseg_tick.sv | 40 ++++
 rtl/swervolf_sseg_scan.sv | 114 +++++++++++
 tb/tb_swervolf_sseg_scan.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/swervolf_sseg_pkg.sv
// Shared definitions for the SweRVolf seven-segment scanner: phase type,
// segment bit positions and the active-high hex font.
package swervolf_sseg_pkg;

  typedef enum logic {
    PH_GAP = 1'b0,
    PH_ON  = 1'b1
  } phase_t;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  // Entry 15 is listed first so that SSEG_FONT[n] is the glyph for hex digit n.
  localparam logic [15:0][6:0] SSEG_FONT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  function automatic logic [6:0] sseg_font(input logic [3:0] nibble);
    logic [6:0] f;
    f = SSEG_FONT[nibble];
    return {f[SEG_A], f[SEG_B], f[SEG_C], f[SEG_D], f[SEG_E], f[SEG_F], f[SEG_G]};
  endfunction

endpackage

// File: rtl/swervolf_sseg_tick.sv
// Slot prescaler: counts 0..CLK_DIV-1, flags the last cycle of a slot and
// whether the current cycle lies past the anode-off gap.
module swervolf_sseg_tick #(
  parameter int CLK_DIV      = 12500,
  parameter int BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic o_adv,
  output logic o_on
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign o_adv = (cnt_reg == CNT_LAST);

  // A zero-length gap would make the compare trivially true, so tie it off.
  generate
    if (BLANK_CYCLES == 0) begin : g_no_gap
      assign o_on = 1'b1;
    end else begin : g_gap
      localparam logic [CNT_W-1:0] BLANK_C = CNT_W'(BLANK_CYCLES);
      assign o_on = (cnt_reg >= BLANK_C);
    end
  endgenerate

endmodule

// File: rtl/swervolf_sseg_scan.sv
// Time-multiplexed common-anode seven-segment scanner with per-slot blanking gap.
// Optional leading-zero blanking is compiled in with SSEG_LZ_BLANK_EN.
module swervolf_sseg_scan
  import swervolf_sseg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 12500,
  parameter int BLANK_CYCLES = 16,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   i_value,
  input  logic [DIGITS-1:0]     i_dp,
  input  logic [DIGITS-1:0]     i_digit_en,
  input  logic                  i_load,
  output logic [DIGITS-1:0]     o_an,
  output logic [6:0]            o_seg,
  output logic                  o_dp
);

  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  logic                adv;
  logic                on;
  phase_t              phase;
  logic [4*DIGITS-1:0] snap_val_reg;
  logic [DIGITS-1:0]   snap_dp_reg;
  logic [DIG_W-1:0]    dig_reg;
  logic [DIGITS-1:0]   vis_mask;
  logic                lit;
  logic [3:0]          cur_nib;
  logic [DIGITS-1:0]   an_next;
  logic [6:0]          seg_next;
  logic                dp_next;
  logic [DIGITS-1:0]   an_reg;
  logic [6:0]          seg_reg;
  logic                dp_reg;

  swervolf_sseg_tick #(
    .CLK_DIV      (CLK_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .o_adv (adv),
    .o_on  (on)
  );

  // The phase is a pure function of the prescaler count; no separate state.
  assign phase = on ? PH_ON : PH_GAP;

`ifdef SSEG_LZ_BLANK_EN
  logic [DIGITS-1:0] lz_blank;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_first
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = ~|snap_val_reg[4*DIGITS-1:4*gi];
      end
    end
  endgenerate

  assign vis_mask = i_digit_en & ~lz_blank;
`else
  assign vis_mask = i_digit_en;
`endif

  assign lit     = (phase == PH_ON) && vis_mask[dig_reg];
  assign cur_nib = snap_val_reg[{dig_reg, 2'b00} +: 4];

  // A disabled or blanked slot drives nothing at all, decimal point included.
  always_comb begin
    an_next  = '0;
    seg_next = '0;
    dp_next  = 1'b0;
    if (lit) begin
      an_next  = DIGITS'(1) << dig_reg;
      seg_next = sseg_font(cur_nib);
      dp_next  = snap_dp_reg[dig_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_val_reg <= '0;
      snap_dp_reg  <= '0;
      dig_reg      <= '0;
      an_reg       <= {DIGITS{POL}};
      seg_reg      <= {7{POL}};
      dp_reg       <= POL;
    end else begin
      if (i_load) begin
        snap_val_reg <= i_value;
        snap_dp_reg  <= i_dp;
      end
      if (adv) begin
        dig_reg <= (dig_reg == DIG_LAST) ? '0 : dig_reg + DIG_W'(1);
      end
      an_reg  <= an_next ^ {DIGITS{POL}};
      seg_reg <= seg_next ^ {7{POL}};
      dp_reg  <= dp_next ^ POL;
    end
  end

  assign o_an  = an_reg;
  assign o_seg = seg_reg;
  assign o_dp  = dp_reg;

endmodule

// File: tb/tb_swervolf_sseg_scan.sv
// Directed bench for swervolf_sseg_scan with DIGITS=8, CLK_DIV=16, BLANK_CYCLES=2,
// ACTIVE_LOW=1. Honours SSEG_LZ_BLANK_EN when the design is built with it.
module tb_swervolf_sseg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_value;
  logic [7:0]  i_dp;
  logic [7:0]  i_digit_en;
  logic        i_load;
  logic [7:0]  o_an;
  logic [6:0]  o_seg;
  logic        o_dp;

  int total = 0;
  int bad = 0;
  int edge_n = 0;

  swervolf_sseg_scan #(
    .DIGITS       (8),
    .CLK_DIV      (16),
    .BLANK_CYCLES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_value    (i_value),
    .i_dp       (i_dp),
    .i_digit_en (i_digit_en),
    .i_load     (i_load),
    .o_an       (o_an),
    .o_seg      (o_seg),
    .o_dp       (o_dp)
  );

  always #5 clk = ~clk;

  // Active-low glyphs, written out by hand.
  function automatic logic [6:0] font_n(input logic [3:0] n);
    case (n)
      4'h0: return 7'h01;
      4'h1: return 7'h4F;
      4'h2: return 7'h12;
      4'h3: return 7'h06;
      4'h4: return 7'h4C;
      4'h5: return 7'h24;
      4'h6: return 7'h20;
      4'h7: return 7'h0F;
      4'h8: return 7'h00;
      4'h9: return 7'h04;
      4'hA: return 7'h08;
      4'hB: return 7'h60;
      4'hC: return 7'h31;
      4'hD: return 7'h42;
      4'hE: return 7'h30;
      default: return 7'h38;
    endcase
  endfunction

  // Expected {o_an, o_seg, o_dp} for prescaler count c and digit d.
  function automatic logic [15:0] exp_out(input int c, input int d, input logic [31:0] val,
                                          input logic [7:0] dp, input logic [7:0] en);
    logic vis;
    vis = (c >= 2) && en[d];
`ifdef SSEG_LZ_BLANK_EN
    if (d > 0 && (val >> (4 * d)) == 32'd0) vis = 1'b0;
`endif
    if (!vis) return {8'hFF, 7'h7F, 1'b1};
    return {~(8'd1 << d), font_n(val[4*d +: 4]), ~dp[d]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] an, input logic [6:0] seg, input logic dp);
    chk({tag, ".an"}, 32'(o_an), 32'(an));
    chk({tag, ".seg"}, 32'(o_seg), 32'(seg));
    chk({tag, ".dp"}, 32'(o_dp), 32'(dp));
    $display("step %s: edge=%0d an=%02h seg=%02h dp=%0b", tag, edge_n, o_an, o_seg, o_dp);
  endtask

  task automatic cyc();
    @(negedge clk);
    edge_n++;
  endtask

  // Align to a frame boundary, then check every cycle of one 128-cycle frame.
  task automatic check_frame(input string tag, input logic [31:0] val,
                             input logic [7:0] dp, input logic [7:0] en);
    logic [15:0] e;
    int guard;
    guard = 0;
    while ((edge_n % 128) != 0 && guard < 128) begin
      cyc();
      guard++;
    end
    for (int k = 0; k < 128; k++) begin
      cyc();
      e = exp_out(k % 16, k / 16, val, dp, en);
      chk($sformatf("%s.d%0d.c%0d.an", tag, k / 16, k % 16), 32'(o_an), 32'(e[15:8]));
      chk($sformatf("%s.d%0d.c%0d.seg", tag, k / 16, k % 16), 32'(o_seg), 32'(e[7:1]));
      chk($sformatf("%s.d%0d.c%0d.dp", tag, k / 16, k % 16), 32'(o_dp), 32'(e[0]));
      if (k % 16 == 15)
        $display("frame %s slot %0d: an=%02h seg=%02h dp=%0b", tag, k / 16, o_an, o_seg, o_dp);
    end
  endtask

  initial begin
    rst        = 1'b1;
    i_value    = 32'h0;
    i_dp       = 8'h0;
    i_digit_en = 8'h0;
    i_load     = 1'b0;
    repeat (3) @(negedge clk);
    chk_out("reset", 8'hFF, 7'h7F, 1'b1);

    // Release reset: gap for two cycles, digit 0 lights at cycle 3 showing "0".
    rst        = 1'b0;
    i_digit_en = 8'hFF;
    edge_n     = 0;
    cyc();
    chk_out("post_rst_c1", 8'hFF, 7'h7F, 1'b1);
    cyc();
    chk_out("post_rst_c2", 8'hFF, 7'h7F, 1'b1);
    cyc();
    chk_out("post_rst_c3", 8'hFE, 7'h01, 1'b1);

    // Full hex pattern with two decimal points.
    i_value = 32'h89ABCDEF;
    i_dp    = 8'h81;
    i_load  = 1'b1;
    cyc();
    i_load  = 1'b0;
    check_frame("hex", 32'h89ABCDEF, 8'h81, 8'hFF);

    // Low four digits disabled; frame timing unchanged.
    i_digit_en = 8'hF0;
    check_frame("en_f0", 32'h89ABCDEF, 8'h81, 8'hF0);

    // Load coincident with the digit-0 to digit-1 advance.
    i_digit_en = 8'hFF;
    while ((edge_n % 128) != 15) cyc();
    i_value = 32'h00000005;
    i_load  = 1'b1;
    cyc();
    i_load  = 1'b0;
    chk_out("adv_load_c15", 8'hFE, 7'h38, 1'b0);
    cyc();
    chk_out("adv_load_gap0", 8'hFF, 7'h7F, 1'b1);
    cyc();
    chk_out("adv_load_gap1", 8'hFF, 7'h7F, 1'b1);
    cyc();
    chk_out("adv_load_on", 8'hFD, 7'h01, 1'b1);
    check_frame("val5", 32'h00000005, 8'h81, 8'hFF);

    // Reset mid-slot (digit 5, cnt 9) clears everything including the snapshot.
    while ((edge_n % 128) != 89) cyc();
    rst = 1'b1;
    cyc();
    chk_out("mid_rst", 8'hFF, 7'h7F, 1'b1);
    rst    = 1'b0;
    edge_n = 0;
    cyc();
    cyc();
    chk_out("mid_rst_c2", 8'hFF, 7'h7F, 1'b1);
    cyc();
    chk_out("mid_rst_c3", 8'hFE, 7'h01, 1'b1);
    check_frame("after_rst", 32'h0, 8'h0, 8'hFF);

    // Leading zeros: shown in the default build, blanked with SSEG_LZ_BLANK_EN.
    i_value = 32'h00000120;
    i_dp    = 8'h08;
    i_load  = 1'b1;
    cyc();
    i_load  = 1'b0;
    check_frame("lz", 32'h00000120, 8'h08, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
